// File: rtl/lsu_mem_master.sv
// rtl/lsu_mem_master.sv - load/store initiator driving a word-wide single-port data memory
// Optional alignment checking is enabled by defining LSU_ALIGN_CHECK_EN.
module lsu_mem_master #(
    parameter int mem_addr_w_p  = 10,
    parameter int data_w_p      = 32,
    parameter int byte_addr_w_p = mem_addr_w_p + 2
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic                     req_we_i,
    input  logic [1:0]               req_size_i,
    input  logic                     req_unsigned_i,
    input  logic [byte_addr_w_p-1:0] req_addr_i,
    input  logic [data_w_p-1:0]      req_wdata_i,
    output logic                     rsp_valid_o,
    output logic [data_w_p-1:0]      rsp_rdata_o,
    output logic                     rsp_err_o,
    output logic [mem_addr_w_p-1:0]  mem_addr_o,
    output logic                     mem_rd_en_o,
    output logic                     mem_wr_en_o,
    output logic [data_w_p-1:0]      mem_data_o,
    input  logic [data_w_p-1:0]      mem_data_i
);

    typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, RESP} state_e;

    state_e                   state_q, state_d;
    logic                     we_q;
    logic [1:0]               size_q;
    logic                     unsigned_q;
    logic [byte_addr_w_p-1:0] addr_q;
    logic [data_w_p-1:0]      merge_q;
    logic [data_w_p-1:0]      rdata_q;
    logic                     err_q;

    logic                     accept;
    logic                     misaligned;
    logic [byte_addr_w_p-1:0] addr_al;

    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] sz,
                                             input logic [1:0] ln, input logic uns);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        sh = w >> {ln, 3'b000};
        b  = sh[7:0];
        h  = ln[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   load_ext = uns ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   load_ext = uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: load_ext = w;
        endcase
    endfunction

    function automatic logic [31:0] st_merge(input logic [31:0] w, input logic [15:0] d,
                                             input logic [1:0] sz, input logic [1:0] ln);
        logic [31:0] m;
        m = w;
        if (sz == 2'b00) begin
            m[{ln, 3'b000} +: 8] = d[7:0];
        end else if (ln[1]) begin
            m[31:16] = d;
        end else begin
            m[15:0] = d;
        end
        st_merge = m;
    endfunction

    always_comb begin
        misaligned = 1'b0;
        addr_al    = req_addr_i;
`ifdef LSU_ALIGN_CHECK_EN
        misaligned = ((req_size_i == 2'b01) && req_addr_i[0]) ||
                     (req_size_i[1] && (req_addr_i[1:0] != 2'b00));
`else
        if (req_size_i == 2'b01) begin
            addr_al[0] = 1'b0;
        end else if (req_size_i[1]) begin
            addr_al[1:0] = 2'b00;
        end
`endif
    end

    // Ready is gated by reset so nothing is accepted while held in reset.
    assign accept = req_valid_i && req_ready_o;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        req_ready_o = 1'b0;
        mem_rd_en_o = 1'b0;
        mem_wr_en_o = 1'b0;
        rsp_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_o = rstn_i;
                if (req_valid_i && rstn_i) begin
                    if (misaligned) begin
                        state_d = RESP;
                    end else if (req_we_i && req_size_i[1]) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                mem_rd_en_o = 1'b1;
                state_d     = RD_WAIT;
            end
            RD_WAIT: state_d = we_q ? WR : RESP;
            WR: begin
                mem_wr_en_o = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // merge_q holds the store data at accept and the merged word after RD_WAIT.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            addr_q     <= '0;
            merge_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            if (accept) begin
                we_q       <= req_we_i;
                size_q     <= req_size_i;
                unsigned_q <= req_unsigned_i;
                addr_q     <= addr_al;
                merge_q    <= req_wdata_i;
                if (misaligned) begin
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                end
            end
            if (state_q == RD_WAIT) begin
                if (we_q) begin
                    merge_q <= st_merge(mem_data_i, merge_q[15:0], size_q, addr_q[1:0]);
                end else begin
                    rdata_q <= load_ext(mem_data_i, size_q, addr_q[1:0], unsigned_q);
                    err_q   <= 1'b0;
                end
            end
            if (state_q == WR) begin
                rdata_q <= '0;
                err_q   <= 1'b0;
            end
        end
    end

    assign mem_addr_o  = addr_q[byte_addr_w_p-1:2];
    assign mem_data_o  = merge_q;
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb/tb_lsu_mem_master.sv - self-checking bench for lsu_mem_master with a byte-level reference model
module tb_lsu_mem_master;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready_o;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [11:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic [9:0]  mem_addr_o;
    logic        mem_rd_en_o;
    logic        mem_wr_en_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_rdata = '0;

    lsu_mem_master dut (
        .clk_i(clk), .rstn_i(rstn),
        .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_we_i(req_we),
        .req_size_i(req_size), .req_unsigned_i(req_unsigned), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata), .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o), .mem_addr_o(mem_addr_o), .mem_rd_en_o(mem_rd_en_o),
        .mem_wr_en_o(mem_wr_en_o), .mem_data_o(mem_data_o), .mem_data_i(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:1023];
    logic [7:0]  refm [0:4095];
    int cyc = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_wr_en_o) begin
            mem[mem_addr_o] <= mem_data_o;
            wr_cnt <= wr_cnt + 1;
        end
        if (mem_rd_en_o) begin
            mem_rdata <= mem[mem_addr_o];
            rd_cnt <= rd_cnt + 1;
        end
    end

    typedef struct { int acc; int due; logic [31:0] rdata; logic err; } rsp_t;
    typedef struct { int due; logic [9:0] a; logic [31:0] d; } mt_t;
    rsp_t rq[$];
    mt_t  rdq[$];
    mt_t  wrq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("strobes_exclusive", 32'(mem_rd_en_o && mem_wr_en_o), 32'd0);
            if (rq.size() != 0 && cyc > rq[0].acc) chk("ready_busy", 32'(req_ready_o), 32'd0);
            else if (rq.size() == 0) chk("ready_idle", 32'(req_ready_o), 32'd1);
            if (mem_rd_en_o) begin
                if (rdq.size() != 0 && rdq[0].due == cyc) begin
                    chk("rd_addr", 32'(mem_addr_o), 32'(rdq[0].a));
                    rdq.delete(0);
                end else chk("rd_strobe_unexpected", 32'(mem_rd_en_o), 32'd0);
            end else if (rdq.size() != 0 && rdq[0].due <= cyc) begin
                chk("rd_strobe_missing", 32'(mem_rd_en_o), 32'd1);
                rdq.delete(0);
            end
            if (mem_wr_en_o) begin
                if (wrq.size() != 0 && wrq[0].due == cyc) begin
                    chk("wr_addr", 32'(mem_addr_o), 32'(wrq[0].a));
                    chk("wr_data", mem_data_o, wrq[0].d);
                    wrq.delete(0);
                end else chk("wr_strobe_unexpected", 32'(mem_wr_en_o), 32'd0);
            end else if (wrq.size() != 0 && wrq[0].due <= cyc) begin
                chk("wr_strobe_missing", 32'(mem_wr_en_o), 32'd1);
                wrq.delete(0);
            end
            if (rsp_valid_o) begin
                if (rq.size() != 0 && rq[0].due == cyc) begin
                    chk("rsp_rdata", rsp_rdata_o, rq[0].rdata);
                    chk("rsp_err", 32'(rsp_err_o), 32'(rq[0].err));
                    rq.delete(0);
                end else chk("rsp_valid_unexpected", 32'(rsp_valid_o), 32'd0);
            end else if (rq.size() != 0 && rq[0].due <= cyc) begin
                chk("rsp_valid_missing", 32'(rsp_valid_o), 32'd1);
                rq.delete(0);
            end
        end
    end

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic issue(input bit we, input logic [1:0] sz, input bit uns, input logic [11:0] a,
                         input logic [31:0] wd, input logic [31:0] lit, input bit apply);
        int k, n, w;
        bit mis;
        logic [11:0] ea, wa;
        logic [31:0] v;
        logic [7:0] sav [4];
        rsp_t r;
        mt_t m;
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        w = 0;
        while (!req_ready_o && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready_o) chk("accept_timeout", 32'(req_ready_o), 32'd1);
        k = cyc;
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        mis = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
        mis = (int'(a) % n) != 0;
`endif
        ea = a - 12'(int'(a) % n);
        wa = {ea[11:2], 2'b00};
        v = '0;
        if (mis) begin
            r = '{k, k + 1, 32'd0, 1'b1};
        end else if (!we) begin
            for (int i = 0; i < n; i++) v = v | (32'(refm[ea + 12'(i)]) << (8 * i));
            if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
            r = '{k, k + 3, v, 1'b0};
            m = '{k + 1, wa[11:2], 32'd0};
            rdq.push_back(m);
        end else begin
            for (int i = 0; i < 4; i++) sav[i] = refm[wa + 12'(i)];
            for (int i = 0; i < n; i++) refm[ea + 12'(i)] = wd[8*i +: 8];
            m.d = {refm[wa + 12'd3], refm[wa + 12'd2], refm[wa + 12'd1], refm[wa]};
            m.a = wa[11:2];
            m.due = k + ((n == 4) ? 1 : 3);
            wrq.push_back(m);
            if (n < 4) begin
                m = '{k + 1, wa[11:2], 32'd0};
                rdq.push_back(m);
            end
            r = '{k, k + ((n == 4) ? 2 : 4), 32'd0, 1'b0};
            if (!apply) for (int i = 0; i < 4; i++) refm[wa + 12'(i)] = sav[i];
        end
        rq.push_back(r);
        chk("model_vs_literal", r.rdata, lit);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (rq.size() != 0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (rq.size() != 0) begin
            chk("completion_timeout", 32'(rq.size()), 32'd0);
            rq.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rd0, wr0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        for (int i = 0; i < 4096; i++) refm[i] = '0;
        #1;
        chk("reset_ready", 32'(req_ready_o), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("reset_rdata", rsp_rdata_o, 32'd0);
        chk("reset_err", 32'(rsp_err_o), 32'd0);
        chk("reset_strobes", 32'({mem_rd_en_o, mem_wr_en_o}), 32'd0);
        chk("reset_mem_addr", 32'(mem_addr_o), 32'd0);
        chk("reset_mem_data", mem_data_o, 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("ready_after_reset", 32'(req_ready_o), 32'd1);
        chk_en = 1'b1;
        @(negedge clk);

        issue(1, 2'b10, 0, 12'h010, 32'hDEADBEEF, 32'h0, 1); wait_idle();
        issue(0, 2'b10, 0, 12'h010, 32'h0, 32'hDEADBEEF, 1); wait_idle();
        issue(1, 2'b00, 0, 12'h013, 32'h000000A5, 32'h0, 1); wait_idle();
        issue(0, 2'b10, 0, 12'h010, 32'h0, 32'hA5ADBEEF, 1); wait_idle();
        issue(0, 2'b00, 0, 12'h013, 32'h0, 32'hFFFFFFA5, 1); wait_idle();
        issue(0, 2'b00, 1, 12'h013, 32'h0, 32'h000000A5, 1); wait_idle();
        issue(1, 2'b01, 0, 12'h010, 32'h00001234, 32'h0, 1); wait_idle();
        issue(0, 2'b01, 0, 12'h012, 32'h0, 32'hFFFFA5AD, 1); wait_idle();

        rd0 = rd_cnt; wr0 = wr_cnt;
`ifdef LSU_ALIGN_CHECK_EN
        issue(0, 2'b01, 1, 12'h011, 32'h0, 32'h00000000, 1); wait_idle();
        chk("misaligned_no_rd", 32'(rd_cnt - rd0), 32'd0);
`else
        issue(0, 2'b01, 1, 12'h011, 32'h0, 32'h00001234, 1); wait_idle();
        chk("forced_align_rd", 32'(rd_cnt - rd0), 32'd1);
`endif
        chk("half_load_no_wr", 32'(wr_cnt - wr0), 32'd0);

        issue(1, 2'b00, 0, 12'h011, 32'h00000077, 32'h0, 0);
        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        chk("rmw_in_wr", 32'(mem_wr_en_o), 32'd1);
        rstn = 1'b0;
        #1;
        chk("rst_async_strobes", 32'({mem_rd_en_o, mem_wr_en_o}), 32'd0);
        chk("rst_async_rsp", 32'(rsp_valid_o), 32'd0);
        rq.delete(); rdq.delete(); wrq.delete();
        repeat (2) begin
            @(negedge clk);
            chk("rst_no_rsp", 32'(rsp_valid_o), 32'd0);
        end
        rstn = 1'b1;
        #1;
        chk("rst_idle_ready", 32'(req_ready_o), 32'd1);
        chk_en = 1'b1;
        @(negedge clk);
        issue(0, 2'b10, 0, 12'h010, 32'h0, 32'hA5AD1234, 1); wait_idle();

        issue(1, 2'b10, 0, 12'h100, 32'h11223344, 32'h0, 1);
        issue(0, 2'b00, 0, 12'h101, 32'h0, 32'h00000033, 1);
        issue(1, 2'b01, 0, 12'h102, 32'h0000BEEF, 32'h0, 1);
        issue(0, 2'b10, 0, 12'h100, 32'h0, 32'hBEEF3344, 1);
        issue(0, 2'b11, 0, 12'h100, 32'h0, 32'hBEEF3344, 1);
        wait_idle();
        chk("queues_drained", 32'(rdq.size() + wrq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
